// File: rtl/_regbank32_pkg.sv
// Shared types and sizing for the 32-entry register bank and its read muxes.
package _regbank32_pkg;

    localparam int unsigned WORD_LENGTH = 32;
    localparam int unsigned REG_COUNT   = 32;
    localparam int unsigned REG_SEL_W   = 5;

    typedef enum logic [0:0] {
        RB_IDLE,
        RB_CLEAR
    } regbank_state_t;

endpackage

// File: rtl/_regbank32_dec32.sv
// 5-to-32 one-hot decoder with enable; yields per-entry strobes for the bank.
module _dec32
    import _regbank32_pkg::*;
(
    input  logic                 en,
    input  logic [REG_SEL_W-1:0] sel,
    output logic [REG_COUNT-1:0] strobe_c
);

    always_comb begin
        strobe_c = '0;
        if (en) begin
            strobe_c[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/_regbank32.sv
// Thirty-two-entry register bank: handshaked single write port plus a
// one-entry-per-cycle bulk-clear sweep used for context reset.
module _regbank32
    import _regbank32_pkg::*;
#(
    parameter int unsigned n       = WORD_LENGTH,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [REG_SEL_W-1:0] wr_sel,
    input  logic [n-1:0]         wr_data,
    input  logic                 clr_start,
    output logic                 busy,
    output logic                 clr_done,
    output logic [n-1:0]         out00,
    output logic [n-1:0]         out01,
    output logic [n-1:0]         out02,
    output logic [n-1:0]         out03,
    output logic [n-1:0]         out04,
    output logic [n-1:0]         out05,
    output logic [n-1:0]         out06,
    output logic [n-1:0]         out07,
    output logic [n-1:0]         out08,
    output logic [n-1:0]         out09,
    output logic [n-1:0]         out10,
    output logic [n-1:0]         out11,
    output logic [n-1:0]         out12,
    output logic [n-1:0]         out13,
    output logic [n-1:0]         out14,
    output logic [n-1:0]         out15,
    output logic [n-1:0]         out16,
    output logic [n-1:0]         out17,
    output logic [n-1:0]         out18,
    output logic [n-1:0]         out19,
    output logic [n-1:0]         out20,
    output logic [n-1:0]         out21,
    output logic [n-1:0]         out22,
    output logic [n-1:0]         out23,
    output logic [n-1:0]         out24,
    output logic [n-1:0]         out25,
    output logic [n-1:0]         out26,
    output logic [n-1:0]         out27,
    output logic [n-1:0]         out28,
    output logic [n-1:0]         out29,
    output logic [n-1:0]         out30,
    output logic [n-1:0]         out31
);

    localparam logic [REG_SEL_W-1:0] LAST_SEL = REG_SEL_W'(REG_COUNT - 1);

    regbank_state_t       state;
    regbank_state_t       state_next;
    logic [REG_SEL_W-1:0] cnt;
    logic [REG_SEL_W-1:0] cnt_next;
    logic                 done_next;
    logic                 wr_fire;
    logic                 wr_en;
    logic [REG_COUNT-1:0] wr_strobe;
    logic [REG_COUNT-1:0] clr_strobe;
    logic [n-1:0]         entry [REG_COUNT];

    assign wr_ready = (state == RB_IDLE);
    assign busy     = (state == RB_CLEAR);
    assign wr_fire  = wr_valid && wr_ready;
    // A write to entry 0 still completes the handshake when it is hardwired to zero.
    assign wr_en    = wr_fire && !(ZERO_R0 && (wr_sel == '0));

    _dec32 u_wr_dec (
        .en       (wr_en),
        .sel      (wr_sel),
        .strobe_c (wr_strobe)
    );

    _dec32 u_clr_dec (
        .en       (busy),
        .sel      (cnt),
        .strobe_c (clr_strobe)
    );

    // State, sweep counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RB_IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            clr_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            RB_IDLE: begin
                if (clr_start) begin
                    state_next = RB_CLEAR;
                    cnt_next   = '0;
                end
            end
            RB_CLEAR: begin
                cnt_next = cnt + REG_SEL_W'(1);
                if (cnt == LAST_SEL) begin
                    state_next = RB_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = RB_IDLE;
            end
        endcase
    end

    // Storage: clear strobe wins over write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                if (clr_strobe[i]) begin
                    entry[i] <= '0;
                end else if (wr_strobe[i]) begin
                    entry[i] <= wr_data;
                end
            end
        end
    end

    assign out00 = entry[0];
    assign out01 = entry[1];
    assign out02 = entry[2];
    assign out03 = entry[3];
    assign out04 = entry[4];
    assign out05 = entry[5];
    assign out06 = entry[6];
    assign out07 = entry[7];
    assign out08 = entry[8];
    assign out09 = entry[9];
    assign out10 = entry[10];
    assign out11 = entry[11];
    assign out12 = entry[12];
    assign out13 = entry[13];
    assign out14 = entry[14];
    assign out15 = entry[15];
    assign out16 = entry[16];
    assign out17 = entry[17];
    assign out18 = entry[18];
    assign out19 = entry[19];
    assign out20 = entry[20];
    assign out21 = entry[21];
    assign out22 = entry[22];
    assign out23 = entry[23];
    assign out24 = entry[24];
    assign out25 = entry[25];
    assign out26 = entry[26];
    assign out27 = entry[27];
    assign out28 = entry[28];
    assign out29 = entry[29];
    assign out30 = entry[30];
    assign out31 = entry[31];

endmodule

// File: tb/tb__regbank32.sv
// Self-checking bench for _regbank32: two instances (entry 0 hardwired / writable)
// share stimulus; write results flow through a scoreboard queue, sweeps against a model.
module tb__regbank32;

    typedef struct packed {
        logic        b;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic        clr_start;
    logic        wr_ready_a, busy_a, clr_done_a;
    logic        wr_ready_b, busy_b, clr_done_b;
    logic [31:0] oa [32];
    logic [31:0] ob [32];

    logic [31:0] mdl_a [32];
    logic [31:0] mdl_b [32];
    exp_t        sbq [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    _regbank32 #(.n(32), .ZERO_R0(1'b1)) dut_a (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
        .wr_sel(wr_sel), .wr_data(wr_data), .clr_start(clr_start),
        .busy(busy_a), .clr_done(clr_done_a),
        .out00(oa[0]),  .out01(oa[1]),  .out02(oa[2]),  .out03(oa[3]),
        .out04(oa[4]),  .out05(oa[5]),  .out06(oa[6]),  .out07(oa[7]),
        .out08(oa[8]),  .out09(oa[9]),  .out10(oa[10]), .out11(oa[11]),
        .out12(oa[12]), .out13(oa[13]), .out14(oa[14]), .out15(oa[15]),
        .out16(oa[16]), .out17(oa[17]), .out18(oa[18]), .out19(oa[19]),
        .out20(oa[20]), .out21(oa[21]), .out22(oa[22]), .out23(oa[23]),
        .out24(oa[24]), .out25(oa[25]), .out26(oa[26]), .out27(oa[27]),
        .out28(oa[28]), .out29(oa[29]), .out30(oa[30]), .out31(oa[31])
    );

    _regbank32 #(.n(32), .ZERO_R0(1'b0)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
        .wr_sel(wr_sel), .wr_data(wr_data), .clr_start(clr_start),
        .busy(busy_b), .clr_done(clr_done_b),
        .out00(ob[0]),  .out01(ob[1]),  .out02(ob[2]),  .out03(ob[3]),
        .out04(ob[4]),  .out05(ob[5]),  .out06(ob[6]),  .out07(ob[7]),
        .out08(ob[8]),  .out09(ob[9]),  .out10(ob[10]), .out11(ob[11]),
        .out12(ob[12]), .out13(ob[13]), .out14(ob[14]), .out15(ob[15]),
        .out16(ob[16]), .out17(ob[17]), .out18(ob[18]), .out19(ob[19]),
        .out20(ob[20]), .out21(ob[21]), .out22(ob[22]), .out23(ob[23]),
        .out24(ob[24]), .out25(ob[25]), .out26(ob[26]), .out27(ob[27]),
        .out28(ob[28]), .out29(ob[29]), .out30(ob[30]), .out31(ob[31])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one write and record what each instance must show after the edge.
    task automatic drive_write(input logic [4:0] s, input logic [31:0] d);
        exp_t e;
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_data  = d;
        e.b = 1'b0; e.idx = s; e.val = (s == 5'd0) ? 32'h0 : d;
        sbq.push_back(e);
        e.b = 1'b1; e.val = d;
        sbq.push_back(e);
        mdl_a[s] = (s == 5'd0) ? 32'h0 : d;
        mdl_b[s] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_start = 1'b0;
        for (int i = 0; i < 32; i++) begin mdl_a[i] = '0; mdl_b[i] = '0; end
        step(); step();
        rst = 1'b0;
        step();
        tests++; if (wr_ready_a !== 1'b1 || wr_ready_b !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b/%b want 1", wr_ready_a, wr_ready_b); end
        tests++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy got %b/%b want 0", busy_a, busy_b); end
        tests++; if (clr_done_a !== 1'b0 || clr_done_b !== 1'b0) begin fails++; $display("FAIL reset_clr_done got %b/%b want 0", clr_done_a, clr_done_b); end
        for (int i = 0; i < 32; i++) begin
            tests++; if (oa[i] !== 32'h0 || ob[i] !== 32'h0) begin fails++; $display("FAIL reset_out[%0d] got %h/%h want 0", i, oa[i], ob[i]); end
        end
    endtask

    task automatic test_write();
        exp_t e;
        drive_write(5'd5, 32'hDEAD_BEEF);
        #1;
        tests++; if (oa[5] !== 32'h0) begin fails++; $display("FAIL write_no_bypass got %h want 0", oa[5]); end
        tests++; if (wr_ready_a !== 1'b1) begin fails++; $display("FAIL write_ready got %b want 1", wr_ready_a); end
        step();
        wr_valid = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ((e.b ? ob[e.idx] : oa[e.idx]) !== e.val) begin
                fails++; $display("FAIL write_sb dut%0d out[%0d] got %h want %h", e.b, e.idx, e.b ? ob[e.idx] : oa[e.idx], e.val);
            end
        end
        for (int i = 0; i < 32; i++) begin
            tests++; if (oa[i] !== mdl_a[i]) begin fails++; $display("FAIL write_bank out[%0d] got %h want %h", i, oa[i], mdl_a[i]); end
        end
    endtask

    task automatic test_zero_r0();
        exp_t e;
        drive_write(5'd0, 32'h0000_1234);
        #1;
        tests++; if (wr_ready_a !== 1'b1 || wr_ready_b !== 1'b1) begin fails++; $display("FAIL r0_handshake got %b/%b want 1", wr_ready_a, wr_ready_b); end
        step();
        wr_valid = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ((e.b ? ob[e.idx] : oa[e.idx]) !== e.val) begin
                fails++; $display("FAIL r0_sb dut%0d out[%0d] got %h want %h", e.b, e.idx, e.b ? ob[e.idx] : oa[e.idx], e.val);
            end
        end
    endtask

    task automatic test_back_to_back(input int base);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            drive_write(5'(i), 32'(i + base));
            step();
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                tests++;
                if ((e.b ? ob[e.idx] : oa[e.idx]) !== e.val) begin
                    fails++; $display("FAIL b2b_sb dut%0d out[%0d] got %h want %h", e.b, e.idx, e.b ? ob[e.idx] : oa[e.idx], e.val);
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    // Runs a sweep already started at the last edge; disturbs inputs to prove they are ignored.
    task automatic run_sweep(input int stop_at);
        for (int k = 0; k < 32 && k < stop_at; k++) begin
            tests++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin fails++; $display("FAIL sweep_busy cyc %0d got %b/%b want 1", k, busy_a, busy_b); end
            tests++; if (wr_ready_a !== 1'b0) begin fails++; $display("FAIL sweep_wr_ready cyc %0d got %b want 0", k, wr_ready_a); end
            tests++; if (clr_done_a !== 1'b0) begin fails++; $display("FAIL sweep_clr_done cyc %0d got %b want 0", k, clr_done_a); end
            for (int i = 0; i < 32; i++) begin
                tests++;
                if (oa[i] !== mdl_a[i] || ob[i] !== mdl_b[i]) begin
                    fails++; $display("FAIL sweep_out[%0d] cyc %0d got %h/%h want %h/%h", i, k, oa[i], ob[i], mdl_a[i], mdl_b[i]);
                end
            end
            wr_valid  = (k >= 2 && k < 20);
            wr_sel    = 5'd3;
            wr_data   = 32'hBAD0_BAD0;
            clr_start = (k >= 5 && k < 20);
            mdl_a[k] = '0;
            mdl_b[k] = '0;
            if (k + 1 < stop_at) step();
        end
        wr_valid  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic check_sweep_end(input string tag);
        step();
        tests++; if (busy_a !== 1'b0 || wr_ready_a !== 1'b1) begin fails++; $display("FAIL %s_end busy/ready got %b/%b want 0/1", tag, busy_a, wr_ready_a); end
        tests++; if (clr_done_a !== 1'b1 || clr_done_b !== 1'b1) begin fails++; $display("FAIL %s_done_pulse got %b/%b want 1", tag, clr_done_a, clr_done_b); end
        for (int i = 0; i < 32; i++) begin
            tests++; if (oa[i] !== 32'h0 || ob[i] !== 32'h0) begin fails++; $display("FAIL %s_zero out[%0d] got %h/%h want 0", tag, i, oa[i], ob[i]); end
        end
        step();
        tests++; if (clr_done_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL %s_single_pulse done/busy got %b/%b want 0/0", tag, clr_done_a, busy_a); end
    endtask

    task automatic test_clear();
        test_back_to_back(0);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        run_sweep(32);
        check_sweep_end("clear");
    endtask

    task automatic test_clear_with_write();
        drive_write(5'd31, 32'h0000_00AA);
        clr_start = 1'b1;
        sbq.delete();
        step();
        wr_valid  = 1'b0;
        clr_start = 1'b0;
        tests++; if (oa[31] !== 32'hAA) begin fails++; $display("FAIL samecyc_write got %h want aa", oa[31]); end
        run_sweep(32);
        check_sweep_end("samecyc");
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        test_back_to_back(1);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        run_sweep(11);
        tests++; if (oa[10] !== 32'd11 || oa[9] !== 32'h0) begin fails++; $display("FAIL midrst_pre out9/out10 got %h/%h want 0/b", oa[9], oa[10]); end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            mdl_a[i] = '0; mdl_b[i] = '0;
            tests++; if (oa[i] !== 32'h0 || ob[i] !== 32'h0) begin fails++; $display("FAIL midrst_out[%0d] got %h/%h want 0", i, oa[i], ob[i]); end
        end
        tests++; if (busy_a !== 1'b0 || wr_ready_a !== 1'b1) begin fails++; $display("FAIL midrst_busy/ready got %b/%b want 0/1", busy_a, wr_ready_a); end
        rst = 1'b0;
        drive_write(5'd7, 32'h0BAD_F00D);
        step();
        wr_valid = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if ((e.b ? ob[e.idx] : oa[e.idx]) !== e.val) begin
                fails++; $display("FAIL midrst_write dut%0d out[%0d] got %h want %h", e.b, e.idx, e.b ? ob[e.idx] : oa[e.idx], e.val);
            end
        end
        for (int k = 0; k < 40; k++) begin
            tests++; if (clr_done_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL midrst_no_done cyc %0d done/busy got %b/%b want 0/0", k, clr_done_a, busy_a); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_r0();
        test_clear();
        test_clear_with_write();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/_regbank32.md
# _regbank32

Thirty-two-entry register bank with a handshaked single write port and a sequenced bulk-clear engine. The block owns the storage that the 32-input read multiplexers select from:
- A 5-bit write select is decoded to one of 32 write enables.
- All 32 words are presented in parallel on out00..out31, which feed `_mux32` read ports directly.
- The clear engine zeroes the bank one entry per cycle. The core uses it for context reset without asserting global reset.

## Interface
- n, WORD_LENGTH, word width in bits
- ZERO_R0, 1, when 1, entry 0 ignores writes and always reads 0
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- wr_valid  input  1  write request present
- wr_ready  output  1  bank can accept a write this cycle
- wr_sel  input  5  destination entry index
- wr_data  input  n  word to write
- clr_start  input  1  request bulk clear (sampled in IDLE only)
- busy  output  1  clear sweep in progress
- clr_done  output  1  one-cycle pulse when sweep completes
- out00..out31  output  n each  current contents of entries 0..31

## Operation
- States: IDLE, CLEAR. Reset state is IDLE.
- wr_ready = (state == IDLE), combinational from state. busy = (state == CLEAR).
- **IDLE:**
  - A write fires when wr_valid && wr_ready. entry[wr_sel] <= wr_data at the edge.
  - With ZERO_R0=1, a write to sel 0 is accepted (handshake completes) and the data is discarded.
- **IDLE to CLEAR:** on clr_start, set cnt <= 0 and enter CLEAR.
- **clr_start and a write in the same IDLE cycle:** the write is performed, then CLEAR is entered. The sweep later zeroes that entry as well.
- **CLEAR:**
  - Each cycle: entry[cnt] <= 0, then cnt <= cnt + 1.
  - When cnt == 31, the entry is cleared, state returns to IDLE, and clr_done pulses on the following cycle.
  - cnt is 5 bits wide, so it wraps to 0 after 31.
- **Ignored inputs during CLEAR:** wr_valid is not accepted (wr_ready = 0), and clr_start has no effect. No clear request is queued.
- **Reset:**
  - Values: all entries 0, state IDLE, cnt 0, busy 0, clr_done 0, wr_ready 1.
  - Reset asserted mid-sweep aborts the sweep immediately. No clr_done pulse is produced.
- **Width rules:** wr_sel is used as an unsigned index 0..31. All 32 encodings are valid, so no range check is needed.

## Timing
- Write latency: data is visible on outXX one cycle after the accepting edge. There is no write-to-output bypass.
- Clear duration: exactly 32 cycles with busy high.
  - busy rises the cycle after clr_start is accepted.
  - clr_done is high the cycle after busy falls.
  - wr_ready returns to 1 in the same cycle busy falls.
- Back-to-back writes: one per cycle in IDLE, with no bubbles.
- outXX are register outputs. There is no combinational path from any input to outXX.

## Structure
- Shared package additions:
  - regbank_state_t enum {RB_IDLE, RB_CLEAR}
  - REG_COUNT = 32
  - REG_SEL_W = 5
  - WORD_LENGTH is already defined there.
- Sub-module _dec32: combinational 5-to-32 one-hot decoder with an enable input.
  - It produces per-entry write strobes.
  - It is instantiated twice: once for wr_sel gated by the write fire, once for cnt gated by busy.
  - Each entry's next-state mux is: rst ? 0 : clear_strobe ? 0 : write_strobe ? wr_data : hold.

## Test plan
- Reset, then write 0xDEADBEEF to sel 5 → out05 = 0xDEADBEEF on the next cycle, all other outputs 0.
- ZERO_R0=1, write 0x1234 to sel 0 → handshake completes and out00 stays 0. Repeat with ZERO_R0=0 → out00 = 0x1234.
- Fill all 32 entries with their index, then pulse clr_start → busy high for 32 cycles, outXX zeroes in ascending order one per cycle, single clr_done pulse, wr_ready 0 throughout the sweep.
- Same-cycle write 0xAA to sel 31 and clr_start → out31 = 0xAA for cycles 1..31 of the sweep, 0 after the last cycle.
- Assert rst at sweep cycle 10 with entries 10..31 still nonzero → all outputs 0 immediately, busy 0, no clr_done, and a write accepted on the first cycle after reset.
